// File: rtl/mpsoc_mem_arbiter.sv
// Two-master round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Grants one command per cycle with a bounded hold window and routes read data back by issuer.
module mpsoc_mem_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned HOLD         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [3:0] HOLD_CNT = 4'(HOLD);

    logic                    req0, req1, pick1, grant0, grant1, any_grant, gnt_wr;
    logic                    owner_q, owner_d;
    logic [3:0]              hold_cnt_q, hold_cnt_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_id_q, pipe_id_d;
    logic                    rsp_vld, rsp_id;

    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        // On contention the owner keeps the grant until its window is used up.
        if (req0 & req1) begin
            pick1 = (hold_cnt_q == HOLD_CNT) ? ~owner_q : owner_q;
        end else begin
            pick1 = req1;
        end
        grant1    = ~reset & req1 & pick1;
        grant0    = ~reset & req0 & ~pick1;
        any_grant = grant0 | grant1;
        gnt_wr    = any_grant & (grant1 ? m1_write : m0_write);

        m0_waitrequest = ~grant0;
        m1_waitrequest = ~grant1;

        mem_address    = grant1 ? m1_address    : m0_address;
        mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
        mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
        mem_chipselect = any_grant;
        mem_write      = gnt_wr;
        mem_clken      = 1'b1;
    end

    always_comb begin
        owner_d    = owner_q;
        hold_cnt_d = '0;
        if (any_grant) begin
            owner_d = grant1;
            if (grant1 != owner_q) begin
                hold_cnt_d = 4'd1;
            end else if (grant1 ? req0 : req1) begin
                hold_cnt_d = (hold_cnt_q == HOLD_CNT) ? HOLD_CNT : hold_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        pipe_vld_d    = '0;
        pipe_id_d     = '0;
        pipe_vld_d[0] = any_grant & ~gnt_wr;
        pipe_id_d[0]  = grant1;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    always_comb begin
        // Gate with reset so a read in flight when reset arrives never responds.
        rsp_vld          = pipe_vld_q[READ_LATENCY-1] & ~reset;
        rsp_id           = pipe_id_q[READ_LATENCY-1];
        m0_readdatavalid = rsp_vld & ~rsp_id;
        m1_readdatavalid = rsp_vld & rsp_id;
        m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
        m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= 1'b0;
            hold_cnt_q <= '0;
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

endmodule
